// File: rtl/io_port_bank_pkg.sv
// Shared types and default widths for the io_port_bank slice.
package io_port_bank_pkg;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_GPIO_W      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_BIDIR_W     = 1;

    // Width of the optional transfer counter.
    localparam int XFER_CNT_W      = 16;

endpackage

// File: rtl/io_port_bank_sync.sv
// io_sync: multi-flop synchroniser for asynchronous pad inputs.
// Every flop resets to 0, so a freshly reset chain reads all-zero.
module io_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    // Shift the asynchronous sample through STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: chip-edge port bank between pad ring and core.
//   - valid/ready 2-entry skid buffer on the data path
//   - direction-controlled bidirectional pins with synchronised readback
//   - synchronised GPIO inputs with rise/fall pulses, GPIO output register
// Optional build macro IO_PORT_BANK_XFER_CNT_EN adds a saturating 16-bit
// pop counter (xfer_cnt) with a clear input (xfer_cnt_clr).
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BIDIR_W     = DEF_BIDIR_W,
    parameter int GPIO_W      = DEF_GPIO_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    inout  wire  [BIDIR_W-1:0] bidir_io,
    input  logic               bidir_dir_we,
    input  logic [BIDIR_W-1:0] bidir_dir_wdata,
    input  logic [BIDIR_W-1:0] bidir_out_wdata,
    output logic [BIDIR_W-1:0] bidir_in_sync,
    input  logic [GPIO_W-1:0]  gpio_in,
    output logic [GPIO_W-1:0]  gpio_in_sync,
    output logic [GPIO_W-1:0]  gpio_rise,
    output logic [GPIO_W-1:0]  gpio_fall,
    input  logic               gpio_out_we,
    input  logic [GPIO_W-1:0]  gpio_out_wdata,
    output logic [GPIO_W-1:0]  gpio_out
`ifdef IO_PORT_BANK_XFER_CNT_EN
    ,
    input  logic               xfer_cnt_clr,
    output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_push;
    logic              w_pop;
    logic              w_main_ld_in;
    logic              w_main_ld_skid;
    logic              w_skid_ld;

    // in_ready depends only on registered state, which breaks the
    // combinational ready path from downstream back to upstream.
    assign in_ready  = (r_state != SKID_TWO);
    assign out_valid = (r_state != SKID_EMPTY);
    assign out_data  = r_main;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // Next-state and register-load decode for the skid buffer.
    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_push) begin
                    w_state_nxt  = SKID_ONE;
                    w_main_ld_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_push && w_pop) begin
                    w_main_ld_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = SKID_TWO;
                    w_skid_ld   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_state_nxt    = SKID_ONE;
                    w_main_ld_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = SKID_EMPTY;
            end
        endcase
    end

    // Occupancy state; reset drops any buffered words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main (output) register; cleared on reset so no stale word is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
        end else if (w_main_ld_in) begin
            r_main <= in_data;
        end else if (w_main_ld_skid) begin
            r_main <= r_skid;
        end
    end

    // Skid register; its content is only observed through r_main while
    // the state says it is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_skid_ld) begin
            r_skid <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Bidirectional pins
    // ------------------------------------------------------------------
    logic [BIDIR_W-1:0] r_dir;
    logic [BIDIR_W-1:0] r_drv;

    // Direction and drive value are written together by one strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= '0;
            r_drv <= '0;
        end else if (bidir_dir_we) begin
            r_dir <= bidir_dir_wdata;
            r_drv <= bidir_out_wdata;
        end
    end

    for (genvar gi = 0; gi < BIDIR_W; gi++) begin : g_pad
        assign bidir_io[gi] = r_dir[gi] ? r_drv[gi] : 1'bz;
    end

    // Readback samples the pad itself, so a driven pin reads its own value.
    io_sync #(
        .WIDTH  (BIDIR_W),
        .STAGES (SYNC_STAGES)
    ) u_bidir_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bidir_io),
        .o_q   (bidir_in_sync)
    );

    // ------------------------------------------------------------------
    // GPIO inputs
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] w_gpio_sync;
    logic [GPIO_W-1:0] r_gpio_prev;

    io_sync #(
        .WIDTH  (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_gpio_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (gpio_in),
        .o_q   (w_gpio_sync)
    );

    // Previous synchronised level; resetting to 0 makes an input held high
    // through reset produce exactly one rise pulse after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_prev <= '0;
        end else begin
            r_gpio_prev <= w_gpio_sync;
        end
    end

    assign gpio_in_sync = w_gpio_sync;
    assign gpio_rise    = w_gpio_sync & ~r_gpio_prev;
    assign gpio_fall    = ~w_gpio_sync & r_gpio_prev;

    // ------------------------------------------------------------------
    // GPIO outputs
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] r_gpio_out;

    // Write-strobed output register, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gpio_out <= '0;
        end else if (gpio_out_we) begin
            r_gpio_out <= gpio_out_wdata;
        end
    end

    assign gpio_out = r_gpio_out;

`ifdef IO_PORT_BANK_XFER_CNT_EN
    // ------------------------------------------------------------------
    // Transfer counter
    // ------------------------------------------------------------------
    logic [XFER_CNT_W-1:0] r_xfer_cnt;

    function automatic logic [XFER_CNT_W-1:0] sat_inc(
        input logic [XFER_CNT_W-1:0] v
    );
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Counts pops, saturating; clear takes priority over a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (xfer_cnt_clr) begin
            r_xfer_cnt <= '0;
        end else if (w_pop) begin
            r_xfer_cnt <= sat_inc(r_xfer_cnt);
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Directed testbench for io_port_bank: table-driven skid-buffer vectors
// plus hand-written sequences for reset, bidir pins, GPIO and counter.
`timescale 1ns/1ps
module tb_io_port_bank;

    localparam int DATA_W      = 8;
    localparam int BIDIR_W     = 1;
    localparam int GPIO_W      = 4;
    localparam int SYNC_STAGES = 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    wire  [BIDIR_W-1:0] bidir_io;
    logic               bidir_dir_we;
    logic [BIDIR_W-1:0] bidir_dir_wdata;
    logic [BIDIR_W-1:0] bidir_out_wdata;
    logic [BIDIR_W-1:0] bidir_in_sync;
    logic [GPIO_W-1:0]  gpio_in;
    logic [GPIO_W-1:0]  gpio_in_sync;
    logic [GPIO_W-1:0]  gpio_rise;
    logic [GPIO_W-1:0]  gpio_fall;
    logic               gpio_out_we;
    logic [GPIO_W-1:0]  gpio_out_wdata;
    logic [GPIO_W-1:0]  gpio_out;
`ifdef IO_PORT_BANK_XFER_CNT_EN
    logic               xfer_cnt_clr;
    logic [15:0]        xfer_cnt;
`endif

    // External pad driver (stands in for the board pulling the pin).
    logic               pad_en;
    logic [BIDIR_W-1:0] pad_val;
    assign bidir_io = pad_en ? pad_val : {BIDIR_W{1'bz}};

    io_port_bank #(
        .DATA_W      (DATA_W),
        .BIDIR_W     (BIDIR_W),
        .GPIO_W      (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .bidir_io        (bidir_io),
        .bidir_dir_we    (bidir_dir_we),
        .bidir_dir_wdata (bidir_dir_wdata),
        .bidir_out_wdata (bidir_out_wdata),
        .bidir_in_sync   (bidir_in_sync),
        .gpio_in         (gpio_in),
        .gpio_in_sync    (gpio_in_sync),
        .gpio_rise       (gpio_rise),
        .gpio_fall       (gpio_fall),
        .gpio_out_we     (gpio_out_we),
        .gpio_out_wdata  (gpio_out_wdata),
        .gpio_out        (gpio_out)
`ifdef IO_PORT_BANK_XFER_CNT_EN
        ,
        .xfer_cnt_clr    (xfer_cnt_clr),
        .xfer_cnt        (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       e_ir;
        logic       e_ov;
        logic       chk_d;
        logic [7:0] e_od;
    } vec_t;

    vec_t tbl [14];

    task automatic gpio_edge(input logic [3:0] nv, input logic [3:0] er, input logic [3:0] ef);
        gpio_in = nv;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            step();
            chk("gpio_rise_early", gpio_rise, 4'h0);
            chk("gpio_fall_early", gpio_fall, 4'h0);
        end
        step();
        chk("gpio_in_sync", gpio_in_sync, nv);
        chk("gpio_rise", gpio_rise, er);
        chk("gpio_fall", gpio_fall, ef);
        step();
        chk("gpio_rise_clear", gpio_rise, 4'h0);
        chk("gpio_fall_clear", gpio_fall, 4'h0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        // Back-to-back flow.
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        // Backpressure: fill to TWO, blocked push, then drain in order.
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[5]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        // TWO with pop and offered push: push is refused, skid moves up.
        tbl[9]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01};
        tbl[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01};
        tbl[11] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02};
        tbl[12] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_data         = '0;
        out_ready       = 1'b0;
        bidir_dir_we    = 1'b0;
        bidir_dir_wdata = '0;
        bidir_out_wdata = '0;
        gpio_in         = '0;
        gpio_out_we     = 1'b0;
        gpio_out_wdata  = '0;
        pad_en          = 1'b1;
        pad_val         = '0;
`ifdef IO_PORT_BANK_XFER_CNT_EN
        xfer_cnt_clr    = 1'b0;
`endif

        repeat (3) step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_gpio_out", gpio_out, 4'h0);
        chk("rst_gpio_sync", gpio_in_sync, 4'h0);
        chk("rst_gpio_rise", gpio_rise, 4'h0);
        chk("rst_bidir_sync", bidir_in_sync, 1'b0);
        rst_n = 1'b1;
        step();

        // Table-driven skid-buffer vectors.
        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].v;
            in_data   = tbl[i].d;
            out_ready = tbl[i].r;
            step();
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].chk_d) begin
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
            end
        end

        // GPIO output register: write, then hold while strobe is low.
        gpio_out_we = 1'b1; gpio_out_wdata = 4'hA;
        step();
        chk("gpio_out_write", gpio_out, 4'hA);
        gpio_out_we = 1'b0; gpio_out_wdata = 4'h5;
        step();
        chk("gpio_out_hold", gpio_out, 4'hA);

        // Reset while holding two words.
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        step();
        in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("pre_rst_in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_gpio_out", gpio_out, 4'h0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("postrst_out_valid", out_valid, 1'b0);
        in_valid = 1'b1; in_data = 8'h77;
        step();
        in_valid = 1'b0;
        chk("postrst_fresh_valid", out_valid, 1'b1);
        chk("postrst_fresh_data", out_data, 8'h77);
        step();
        chk("postrst_drained", out_valid, 1'b0);

        // GPIO edge pulses.
        gpio_edge(4'b0101, 4'b0101, 4'b0000);
        gpio_edge(4'b0100, 4'b0000, 4'b0001);

        // Bidirectional pin: drive 1, read it back; release and read 0.
        pad_en = 1'b0;
        bidir_dir_we = 1'b1; bidir_dir_wdata = 1'b1; bidir_out_wdata = 1'b1;
        step();
        bidir_dir_we = 1'b0;
        chk("pad_driven", bidir_io, 1'b1);
        repeat (SYNC_STAGES) step();
        chk("bidir_sync_1", bidir_in_sync, 1'b1);
        bidir_dir_we = 1'b1; bidir_dir_wdata = 1'b0; bidir_out_wdata = 1'b1;
        step();
        bidir_dir_we = 1'b0;
        pad_en = 1'b1; pad_val = 1'b0;
        #1;
        chk("pad_released", bidir_io, 1'b0);
        step();
        repeat (SYNC_STAGES) step();
        chk("bidir_sync_0", bidir_in_sync, 1'b0);

`ifdef IO_PORT_BANK_XFER_CNT_EN
        // Counter: clear, stream 65534 pops, then saturate, then clear+pop.
        in_valid = 1'b0; out_ready = 1'b1; xfer_cnt_clr = 1'b1;
        step();
        xfer_cnt_clr = 1'b0;
        chk("cnt_cleared", xfer_cnt, 16'h0000);
        in_valid = 1'b1; in_data = 8'h3C;
        repeat (65535) step();
        chk("cnt_fffe", xfer_cnt, 16'hFFFE);
        repeat (3) step();
        chk("cnt_saturate", xfer_cnt, 16'hFFFF);
        xfer_cnt_clr = 1'b1;
        step();
        chk("cnt_clr_wins", xfer_cnt, 16'h0000);
        xfer_cnt_clr = 1'b0;
        step();
        chk("cnt_after_clr", xfer_cnt, 16'h0001);
        in_valid = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised successor to the team's single-register port module.
- Replaces the bare data_in to data_out flop with a valid/ready 2-entry skid buffer.
- Adds direction-controlled bidirectional pins with synchronised readback.
- Adds synchronised GPIO inputs with rise/fall edge pulses, and a writable GPIO output register.
- Sits at the chip-edge boundary between pad ring and core logic.

Parameters:
- DATA_W, 8, width of the handshaked data path.
- BIDIR_W, 1, number of bidirectional pins.
- GPIO_W, 4, number of GPIO input pins and GPIO output pins.
- SYNC_STAGES, 2, flop depth of input synchronisers (legal 2..4).

Ports:
- clk  input  1  clock; all state is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept in_data.
- in_data  input  DATA_W  upstream data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  registered data.
- bidir_io  inout  BIDIR_W  pad pins.
- bidir_dir_we  input  1  write strobe for direction and drive-value registers.
- bidir_dir_wdata  input  BIDIR_W  new direction; 1 = drive.
- bidir_out_wdata  input  BIDIR_W  new drive value.
- bidir_in_sync  output  BIDIR_W  synchronised pin readback.
- gpio_in  input  GPIO_W  asynchronous inputs.
- gpio_in_sync  output  GPIO_W  synchronised level.
- gpio_rise  output  GPIO_W  one-cycle pulse on 0 to 1 transition.
- gpio_fall  output  GPIO_W  one-cycle pulse on 1 to 0 transition.
- gpio_out_we  input  1  GPIO output write strobe.
- gpio_out_wdata  input  GPIO_W  new GPIO output value.
- gpio_out  output  GPIO_W  registered GPIO output.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - Skid state is EMPTY; out_valid=0, out_data=0, in_ready=1.
  - Direction register=0 (all bidir pins high-Z); drive register=0.
  - All synchroniser flops=0, so bidir_in_sync=0, gpio_in_sync=0, gpio_rise=0, gpio_fall=0.
  - gpio_out=0.
- Skid buffer states:
  - EMPTY: no entries held.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Handshake signals:
  - in_ready = (state != TWO); it is a function of registered state only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY); out_data = main register.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
- Transitions:
  - EMPTY + push: go to ONE; main <= in_data. Latency is 1 cycle, in to out.
  - ONE + push, no pop: go to TWO; skid <= in_data.
  - ONE + pop, no push: go to EMPTY.
  - ONE + push + pop: stay in ONE; main <= in_data.
  - TWO + pop: go to ONE; main <= skid. No push is possible in TWO.
  - All other cases hold state.
- Ordering and throughput:
  - Data is strictly FIFO-ordered.
  - Sustained throughput is 1 word per cycle.
  - out_data is stable while out_valid=1 and out_ready=0.
- Bidirectional pins:
  - On bidir_dir_we=1, the direction register <= bidir_dir_wdata and the drive register <= bidir_out_wdata in the same cycle.
  - bidir_io[i] = drive[i] when dir[i]=1, else high-Z.
  - bidir_in_sync = SYNC_STAGES-flop synchronised pad value, independent of direction. A driven pin reads back its own value after SYNC_STAGES cycles.
- GPIO inputs:
  - gpio_in_sync is SYNC_STAGES-flop synchronised.
  - A prev register (reset 0) holds the last gpio_in_sync value.
  - gpio_rise = sync & ~prev; gpio_fall = ~sync & prev.
  - An input held high through reset produces exactly one rise pulse, SYNC_STAGES cycles after reset release. This is required behaviour.
- GPIO outputs: gpio_out <= gpio_out_wdata when gpio_out_we=1; otherwise it holds.
- Mid-operation reset: a reset asserted mid-stream discards all buffered data immediately; no partial output.

Optional Feature:
- Macro: IO_PORT_BANK_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0]. It increments on every pop and saturates at 16'hFFFF.
  - Adds input port xfer_cnt_clr. When high, it zeroes the count; clear wins over a simultaneous pop.
  - The counter resets to 0.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package io_port_bank_pkg:
  - typedef enum logic [1:0] skid_state_t {SKID_EMPTY, SKID_ONE, SKID_TWO}.
  - Default width constants: DATA_W 8, GPIO_W 4, SYNC_STAGES 2.
- One sub-module, io_sync:
  - Parameters WIDTH and STAGES; async-reset flop chain, reset 0.
  - Instantiated once for bidir_io and once for gpio_in.

Test Plan:
- Back-to-back flow: out_ready=1, push 8'h11, 8'h22, 8'h33 on consecutive cycles -> out_data shows 11, 22, 33, each 1 cycle after its push; in_ready stays 1.
- Backpressure: out_ready=0, push 8'hA5 then 8'h5A -> in_ready=0 after the second push. Then raise out_ready -> A5 then 5A appear in order, and in_ready returns to 1 after the first pop.
- Reset in TWO state: assert rst_n=0 while the buffer holds A5 and 5A -> out_valid=0 and out_data=0 immediately, in_ready=1; no stale data appears after release.
- Bidirectional pin: write dir=1, drive=1 -> the pad reads 1 and bidir_in_sync=1 after 2 cycles. Then write dir=0 with an external weak 0 on the pad -> bidir_in_sync=0 after 2 cycles.
- GPIO edges: gpio_in 4'b0000 -> 4'b0101 -> 4'b0100 -> gpio_rise=4'b0101 for exactly one cycle, then gpio_fall=4'b0001 for exactly one cycle, each at SYNC_STAGES latency.
- Counter (IO_PORT_BANK_XFER_CNT_EN defined): preload 16'hFFFE, perform 3 pops -> count saturates at FFFF. Then assert xfer_cnt_clr together with a pop -> count is 0.
